// File: rtl/serdes_pkg.sv
// Shared state encodings and frame helpers for the parametrised serializer/deserializer.
package serdes_pkg;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_PAR  = 2'd2,
    RX_STOP = 2'd3
  } rx_state_e;

  localparam int MAX_DATA_W = 32;

  function automatic int frame_len(input int data_w, input int parity_en);
    return data_w + 2 + parity_en;
  endfunction

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w);
  endfunction

  // Even parity over a zero-extended word; the extension bits do not change the XOR.
  function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serdes_rx.sv
// Receive side: start detection, data assembly, parity and stop-bit checks.
module serdes_rx
  import serdes_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_par_err,
  output logic              rx_frm_err
);

  localparam int              CNT_W    = bit_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_e         rx_state_r;
  logic [CNT_W-1:0]  rx_cnt_r;
  logic [DATA_W-1:0] rx_sh_r;
  logic [DATA_W-1:0] rx_shift_s;
  logic              rx_par_mis_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;
  logic              rx_par_err_r;
  logic              rx_frm_err_r;

  // Insert the incoming bit so the first received bit ends up in its final position
  always_comb begin
    rx_shift_s = rx_sh_r;
    if (LSB_FIRST != 0) begin
      rx_shift_s = {rx_bit, rx_sh_r[DATA_W-1:1]};
    end else begin
      rx_shift_s = {rx_sh_r[DATA_W-2:0], rx_bit};
    end
  end

  // RX FSM; result registers are loaded in the STOP cycle and flags live for one pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r   <= RX_IDLE;
      rx_cnt_r     <= '0;
      rx_sh_r      <= '0;
      rx_par_mis_r <= 1'b0;
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      rx_par_err_r <= 1'b0;
      rx_frm_err_r <= 1'b0;
    end else begin
      rx_valid_r   <= 1'b0;
      rx_par_err_r <= 1'b0;
      rx_frm_err_r <= 1'b0;
      if (!rx_en) begin
        rx_state_r <= RX_IDLE;
        rx_cnt_r   <= '0;
      end else begin
        case (rx_state_r)
          RX_IDLE: begin
            rx_cnt_r     <= '0;
            rx_par_mis_r <= 1'b0;
            if (!rx_bit) begin
              rx_state_r <= RX_DATA;
            end else begin
              rx_state_r <= RX_IDLE;
            end
          end
          RX_DATA: begin
            rx_sh_r <= rx_shift_s;
            if (rx_cnt_r == LAST_BIT) begin
              rx_cnt_r   <= '0;
              rx_state_r <= (PARITY_EN != 0) ? RX_PAR : RX_STOP;
            end else begin
              rx_cnt_r <= rx_cnt_r + CNT_W'(1);
            end
          end
          RX_PAR: begin
            rx_par_mis_r <= rx_bit ^ even_parity(MAX_DATA_W'(rx_sh_r));
            rx_state_r   <= RX_STOP;
          end
          RX_STOP: begin
            rx_valid_r   <= 1'b1;
            rx_data_r    <= rx_sh_r;
            rx_par_err_r <= rx_par_mis_r;
            rx_frm_err_r <= ~rx_bit;
            rx_state_r   <= RX_IDLE;
          end
          default: begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
          end
        endcase
      end
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign rx_par_err = rx_par_err_r;
  assign rx_frm_err = rx_frm_err_r;

endmodule

// File: rtl/serdes_core.sv
// Framed one-bit-per-clock serializer with loopback-capable deserializer.
module serdes_core
  import serdes_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_out,
  input  logic              ser_in,
  input  logic              rx_en,
  input  logic              loopback,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_par_err,
  output logic              rx_frm_err
);

  localparam int               CNT_W    = bit_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  tx_state_e         tx_state_r;
  logic [DATA_W-1:0] tx_sh_r;
  logic [DATA_W-1:0] tx_shift_s;
  logic              tx_head_s;
  logic [CNT_W-1:0]  tx_cnt_r;
  logic              tx_par_r;
  logic              tx_ready_r;
  logic              tx_accept_s;
  logic              tx_line_nxt_s;
  logic              tx_line_r;
  logic              ser_out_r;
  logic              rx_line_s;
  logic              rx_sync_r;

  assign tx_accept_s = tx_valid & tx_ready_r;
  assign rx_line_s   = loopback ? tx_line_r : ser_in;

  // Next bit to leave the shift register, and the register after it has left
  always_comb begin
    tx_head_s  = 1'b1;
    tx_shift_s = tx_sh_r;
    if (LSB_FIRST != 0) begin
      tx_head_s  = tx_sh_r[0];
      tx_shift_s = {1'b0, tx_sh_r[DATA_W-1:1]};
    end else begin
      tx_head_s  = tx_sh_r[DATA_W-1];
      tx_shift_s = {tx_sh_r[DATA_W-2:0], 1'b0};
    end
  end

  // Line value for the next cycle, decoded from the current TX state
  always_comb begin
    tx_line_nxt_s = 1'b1;
    case (tx_state_r)
      TX_IDLE, TX_STOP: begin
        if (tx_accept_s) begin
          tx_line_nxt_s = 1'b0;
        end else begin
          tx_line_nxt_s = 1'b1;
        end
      end
      TX_START: tx_line_nxt_s = tx_head_s;
      TX_DATA: begin
        if (tx_cnt_r == LAST_BIT) begin
          tx_line_nxt_s = (PARITY_EN != 0) ? tx_par_r : 1'b1;
        end else begin
          tx_line_nxt_s = tx_head_s;
        end
      end
      TX_PAR:  tx_line_nxt_s = 1'b1;
      default: tx_line_nxt_s = 1'b1;
    endcase
  end

  // TX FSM; an accept in STOP chains straight into the next START
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_sh_r    <= '0;
      tx_cnt_r   <= '0;
      tx_par_r   <= 1'b0;
      tx_ready_r <= 1'b1;
    end else begin
      case (tx_state_r)
        TX_IDLE, TX_STOP: begin
          tx_cnt_r <= '0;
          if (tx_accept_s) begin
            tx_state_r <= TX_START;
            tx_sh_r    <= tx_data;
            tx_par_r   <= even_parity(MAX_DATA_W'(tx_data));
            tx_ready_r <= 1'b0;
          end else begin
            tx_state_r <= TX_IDLE;
            tx_ready_r <= 1'b1;
          end
        end
        TX_START: begin
          tx_state_r <= TX_DATA;
          tx_sh_r    <= tx_shift_s;
          tx_ready_r <= 1'b0;
        end
        TX_DATA: begin
          tx_sh_r <= tx_shift_s;
          if (tx_cnt_r == LAST_BIT) begin
            tx_cnt_r <= '0;
            if (PARITY_EN != 0) begin
              tx_state_r <= TX_PAR;
              tx_ready_r <= 1'b0;
            end else begin
              tx_state_r <= TX_STOP;
              tx_ready_r <= 1'b1;
            end
          end else begin
            tx_cnt_r   <= tx_cnt_r + CNT_W'(1);
            tx_ready_r <= 1'b0;
          end
        end
        TX_PAR: begin
          tx_state_r <= TX_STOP;
          tx_ready_r <= 1'b1;
        end
        default: begin
          tx_state_r <= TX_IDLE;
          tx_cnt_r   <= '0;
          tx_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Internal line, pin driver (forced idle in loopback) and the single RX input flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_line_r <= 1'b1;
      ser_out_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      tx_line_r <= tx_line_nxt_s;
      ser_out_r <= loopback | tx_line_nxt_s;
      rx_sync_r <= rx_line_s;
    end
  end

  assign tx_ready = tx_ready_r;
  assign ser_out  = ser_out_r;

  serdes_rx #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST),
    .PARITY_EN(PARITY_EN)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_en     (rx_en),
    .rx_bit    (rx_sync_r),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_par_err(rx_par_err),
    .rx_frm_err(rx_frm_err)
  );

endmodule

// File: tb/tb_serdes_core.sv
// Randomised bench for serdes_core against a frame-level reference model and scoreboard.
module tb_serdes_core;

  typedef bit bitq_t[$];
  typedef struct {
    logic [31:0] data;
    bit          par;
    bit          frm;
    int          at;
  } exp_t;

  localparam int F8 = 8 + 2 + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ser_in = 1'b1;
  logic       rx_en = 1'b0;
  logic       loopback = 1'b0;
  logic       tx_ready, ser_out, rx_valid, rx_par_err, rx_frm_err;
  logic [7:0] rx_data;

  logic [7:0] m_tx_data = 8'h00;
  logic       m_tx_valid = 1'b0;
  logic       m_tx_ready, m_ser_out, m_rx_valid, m_par, m_frm;
  logic [7:0] m_rx_data;

  logic [15:0] w_tx_data = 16'h0000;
  logic        w_tx_valid = 1'b0;
  logic        w_tx_ready, w_ser_out, w_rx_valid, w_par, w_frm;
  logic [15:0] w_rx_data;

  int   checks_cnt = 0;
  int   errors_cnt = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  serdes_core dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ser_out(ser_out), .ser_in(ser_in), .rx_en(rx_en), .loopback(loopback),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_par_err(rx_par_err), .rx_frm_err(rx_frm_err)
  );

  serdes_core #(.DATA_W(8), .LSB_FIRST(0), .PARITY_EN(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .tx_data(m_tx_data), .tx_valid(m_tx_valid), .tx_ready(m_tx_ready),
    .ser_out(m_ser_out), .ser_in(1'b1), .rx_en(1'b0), .loopback(1'b0),
    .rx_data(m_rx_data), .rx_valid(m_rx_valid), .rx_par_err(m_par), .rx_frm_err(m_frm)
  );

  serdes_core #(.DATA_W(16), .LSB_FIRST(1), .PARITY_EN(0)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .tx_data(w_tx_data), .tx_valid(w_tx_valid), .tx_ready(w_tx_ready),
    .ser_out(w_ser_out), .ser_in(1'b1), .rx_en(1'b1), .loopback(1'b1),
    .rx_data(w_rx_data), .rx_valid(w_rx_valid), .rx_par_err(w_par), .rx_frm_err(w_frm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: start, data bits in wire order, optional even parity, stop.
  function automatic bitq_t make_frame(input logic [31:0] d, input int w, input bit lsb, input bit par);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < w; i++) q.push_back(lsb ? d[i] : d[w-1-i]);
    if (par) q.push_back(($countones(d) % 2) == 1);
    q.push_back(1'b1);
    return q;
  endfunction

  task automatic push_exp(input logic [31:0] d, input bit p, input bit f, input int at);
    exp_t e;
    e.data = d; e.par = p; e.frm = f; e.at = at;
    exp_q.push_back(e);
  endtask

  // Scoreboard on the main instance: every pulse must match the oldest expected frame.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rx_unexpected_valid", rx_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rx_data", rx_data, e.data);
        check_eq("rx_par_err", rx_par_err, e.par);
        check_eq("rx_frm_err", rx_frm_err, e.frm);
        check_eq("rx_valid_cycle", cyc, e.at);
      end
    end
  end

  task automatic drain();
    for (int g = 0; g < 60 && exp_q.size() != 0; g++) tick();
    check_eq("drain_pending", exp_q.size(), 0);
  endtask

  // Feed words with tx_valid held, checking the line bit-by-bit (or idle-high in loopback).
  task automatic run_tx(input logic [7:0] ws[$]);
    bitq_t line;
    bitq_t f;
    int    n;
    string tag;
    foreach (ws[i]) begin
      f = make_frame(32'(ws[i]), 8, 1'b1, 1'b1);
      foreach (f[j]) line.push_back(f[j]);
    end
    tag = loopback ? "lb_ser_out_idle" : "tx_line";
    for (int g = 0; g < 40 && !tx_ready; g++) tick();
    check_eq("tx_ready_before_send", tx_ready, 1'b1);
    tx_data = ws[0]; tx_valid = 1'b1; n = 1;
    if (loopback) push_exp(32'(ws[0]), 1'b0, 1'b0, cyc + F8 + 2);
    tick();
    for (int k = 0; k < line.size(); k++) begin
      check_eq(tag, ser_out, loopback ? 1'b1 : line[k]);
      if (tx_ready) begin
        if (n < ws.size()) begin
          tx_data = ws[n];
          if (loopback) push_exp(32'(ws[n]), 1'b0, 1'b0, cyc + F8 + 2);
          n++;
        end else begin
          tx_valid = 1'b0;
        end
      end else begin
        tx_data = 8'($urandom);
      end
      tick();
    end
    tx_valid = 1'b0;
    check_eq("tx_idle_after", ser_out, 1'b1);
  endtask

  // Drive one externally built frame onto ser_in, with optional corruption.
  task automatic send_ext(input logic [7:0] d, input bit flip_par, input bit bad_stop);
    bitq_t f;
    f = make_frame(32'(d), 8, 1'b1, 1'b1);
    if (flip_par) f[F8-2] = ~f[F8-2];
    if (bad_stop) f[F8-1] = 1'b0;
    push_exp(32'(d), f[F8-2] != (($countones(d) % 2) == 1), f[F8-1] == 1'b0, cyc + F8 + 1);
    foreach (f[k]) begin
      ser_in = f[k];
      tick();
    end
    ser_in = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wq[$];
    bitq_t      fq;
    int         a, seen, pulses;
    logic [15:0] got16;

    repeat (2) tick();
    check_eq("rst_tx_ready", tx_ready, 1'b1);
    check_eq("rst_ser_out", ser_out, 1'b1);
    check_eq("rst_rx_data", rx_data, 8'h00);
    check_eq("rst_rx_valid", rx_valid, 1'b0);
    check_eq("rst_rx_par_err", rx_par_err, 1'b0);
    check_eq("rst_rx_frm_err", rx_frm_err, 1'b0);
    rst_n = 1'b1;
    tick();

    loopback = 1'b1; rx_en = 1'b1;
    wq.delete(); wq.push_back(8'hA5); run_tx(wq); drain();
    wq.delete(); wq.push_back(8'h01); wq.push_back(8'hFF); run_tx(wq); drain();
    for (int r = 0; r < 5; r++) begin
      wq.delete(); wq.push_back(8'($urandom));
      run_tx(wq);
      repeat ($urandom_range(0, 3)) tick();
    end
    wq.delete();
    for (int r = 0; r < 3; r++) wq.push_back(8'($urandom));
    run_tx(wq); drain();

    loopback = 1'b0;
    tick();
    send_ext(8'hA5, 1'b0, 1'b0);
    send_ext(8'hA5, 1'b1, 1'b0);
    send_ext(8'hA5, 1'b0, 1'b1);
    for (int r = 0; r < 6; r++) send_ext(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    drain();

    wq.delete();
    for (int r = 0; r < 3; r++) wq.push_back(8'($urandom));
    run_tx(wq);
    repeat (3) tick();

    for (int r = 0; r < 2; r++) begin
      m_tx_data = (r == 0) ? 8'h80 : 8'($urandom);
      fq = make_frame(32'(m_tx_data), 8, 1'b0, 1'b1);
      check_eq("msb_ready", m_tx_ready, 1'b1);
      m_tx_valid = 1'b1;
      tick();
      m_tx_valid = 1'b0;
      foreach (fq[k]) begin
        check_eq("msb_line", m_ser_out, fq[k]);
        tick();
      end
    end

    w_tx_data = 16'hBEEF; w_tx_valid = 1'b1; a = cyc;
    check_eq("w16_ready", w_tx_ready, 1'b1);
    tick();
    w_tx_valid = 1'b0;
    seen = -1; pulses = 0; got16 = 16'h0000;
    for (int k = 0; k < 40; k++) begin
      if (w_rx_valid) begin
        pulses++;
        if (seen < 0) begin seen = cyc; got16 = w_rx_data; end
      end
      tick();
    end
    check_eq("w16_valid_cycle", seen - a, 16 + 2 + 0 + 2);
    check_eq("w16_data", got16, 16'hBEEF);
    check_eq("w16_pulses", pulses, 1);

    loopback = 1'b1;
    tick();
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_tx_ready", tx_ready, 1'b1);
    check_eq("midrst_ser_out", ser_out, 1'b1);
    check_eq("midrst_rx_data", rx_data, 8'h00);
    check_eq("midrst_rx_valid", rx_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (15) tick();
    tx_data = 8'hC3; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (6) tick();
    rx_en = 1'b0;
    repeat (12) tick();
    rx_en = 1'b1;
    repeat (3) tick();
    check_eq("post_abort_rx_data", rx_data, 8'h00);
    check_eq("post_abort_rx_valid", rx_valid, 1'b0);
    check_eq("post_abort_par", rx_par_err, 1'b0);
    check_eq("post_abort_frm", rx_frm_err, 1'b0);
    check_eq("post_abort_tx_ready", tx_ready, 1'b1);
    wq.delete(); wq.push_back(8'h5A); run_tx(wq); drain();

    check_eq("msb_rx_quiet", m_rx_valid, 1'b0);
    check_eq("msb_rx_data", m_rx_data, 8'h00);
    check_eq("msb_flags", {m_par, m_frm}, 2'b00);
    check_eq("w16_flags", {w_par, w_frm}, 2'b00);
    check_eq("w16_ser_out_idle", w_ser_out, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/serdes_core.md
Name: serdes_core

Overview:
- Parametrised successor to the tile's fixed 8-bit SERDES.
- Framed, one-bit-per-clock serializer (TX) and deserializer (RX) on a shared clock.
- TX has a valid/ready parallel input; RX has a one-cycle valid output with parity and framing error flags.
- Has an internal loopback mode; sits directly behind the tile top-level pin mapping.

Parameters:
- DATA_W, 8: parallel word width in bits, 2..32.
- LSB_FIRST, 1: 1 = bit 0 sent first, 0 = MSB first.
- PARITY_EN, 1: 1 = append an even-parity bit, 0 = no parity bit.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_W  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  core accepts a word this cycle when tx_valid is also high.
- ser_out  out  1  serial line out; idles at 1.
- ser_in  in  1  serial line in; idles at 1.
- rx_en  in  1  RX enable.
- loopback  in  1  1 = RX takes the internal TX line; ser_out is held at 1.
- rx_data  out  DATA_W  received word.
- rx_valid  out  1  one-cycle pulse; rx_data and the error flags are valid.
- rx_par_err  out  1  parity mismatch, qualified by rx_valid.
- rx_frm_err  out  1  stop bit was 0, qualified by rx_valid.

Behaviour:
- Reset values:
  - tx_ready=1, ser_out=1.
  - rx_data=0, rx_valid=0, rx_par_err=0, rx_frm_err=0.
  - Both FSMs in IDLE, all counters 0.
  - Reset is honoured mid-frame: the partial frame is discarded and nothing is emitted.
- Frame format: start(0), DATA_W data bits in LSB_FIRST order, parity (if PARITY_EN, even: XOR of data bits), stop(1).
  - Frame length F = DATA_W + 2 + PARITY_EN cycles.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - tx_ready=1 in IDLE and in STOP; 0 otherwise.
  - Handshake: tx_valid & tx_ready in cycle T latches tx_data into the shift register and moves to START.
  - ser_out is registered: start bit appears at T+1, data bit i at T+2+i, parity at T+2+DATA_W, stop at T+2+DATA_W+PARITY_EN.
  - Acceptance in STOP chains straight to START, giving back-to-back frames with no idle cycles.
  - With no acceptance, STOP -> IDLE and ser_out=1.
  - tx_valid high while tx_ready=0 is ignored; tx_data needs to be stable only in the accept cycle.
  - A bit counter runs 0..DATA_W-1 in DATA; at the last bit it moves to PAR, or to STOP when PARITY_EN=0.
- Line select:
  - rx_line = loopback ? tx_line_internal : ser_in.
  - ser_out = loopback ? 1 : tx_line_internal.
  - rx_line is registered once (rx_s); the RX FSM uses only rx_s.
  - loopback may change only while both FSMs are IDLE; otherwise the result is undefined, but it must not deadlock.
- RX FSM states: IDLE, DATA, PAR, STOP.
  - IDLE: rx_s==0 and rx_en=1 -> DATA; the start bit is consumed in that cycle.
  - DATA: shift rx_s into position per LSB_FIRST for DATA_W cycles, then PAR, or STOP when PARITY_EN=0.
  - PAR: compare rx_s with the XOR of the received data bits.
  - STOP: go to IDLE.
  - In the STOP cycle the next-cycle outputs are registered: rx_valid=1, rx_data=assembled word, rx_par_err=mismatch, rx_frm_err=(rx_s==0).
  - rx_valid is exactly one cycle wide. rx_data holds until the next rx_valid; the error flags clear when rx_valid deasserts.
  - A frame with rx_frm_err=1 still returns to IDLE. If the line stays 0, the next cycle starts a new frame, which is intended resync behaviour.
  - rx_en=0 in any state forces IDLE next cycle, drops the partial frame and produces no rx_valid.
  - No RX backpressure; the consumer must take the word within the pulse.
- Loopback latency: accept at cycle 0 -> rx_valid at cycle F+2 (13 for DATA_W=8 with parity).

Decomposition:
- Package serdes_pkg:
  - TX and RX state enums.
  - FRAME_LEN function of (DATA_W, PARITY_EN).
  - Bit-counter width as $clog2(DATA_W).
- One sub-module is natural: serdes_rx (RX FSM, shift register, checks).
- TX FSM, line mux and rx_s flop stay in serdes_core.

Test Plan:
- Loopback=1, DATA_W=8, PARITY_EN=1, send 0xA5 at cycle 0 -> rx_valid at cycle 13, rx_data=0xA5, both error flags 0, ser_out stays 1 throughout.
- Loopback=0, external pattern 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB-first, parity 0, stop) -> rx_data=0xA5, rx_par_err=0.
  - Same pattern with parity bit 1 -> rx_par_err=1.
  - Same pattern with stop bit 0 -> rx_frm_err=1.
- Back-to-back: tx_valid held high with 0x01 then 0xFF -> second frame's start bit is the cycle right after the first stop bit; RX returns 0x01 then 0xFF with rx_valid pulses 11 cycles apart.
- LSB_FIRST=0 with 0x80 -> ser_out sequence 0,1,0,0,0,0,0,0,0,1(parity),1(stop).
- rst_n low for one cycle mid-DATA, then rx_en toggled low mid-frame -> no rx_valid, all outputs at reset values; the next full frame is received correctly.
- DATA_W=16, PARITY_EN=0, send 0xBEEF in loopback -> rx_valid at cycle 20, rx_data=0xBEEF.
